// File: rtl/step_controller.sv
// CPU clock-enable / step controller: manual step, free-run, run-N and run-to-breakpoint.
// Latency: step_button edge -> cpu_enable in 3 clocks; go -> RUN next clock; tick -> cpu_enable next clock.
// No backpressure: go/halt are single-cycle pulses, halt overrides go and any coincident tick.
module step_controller #(
  parameter int COUNT_WIDTH    = 16,
  parameter int ADDR_WIDTH     = 32,
  parameter int PRESCALE_WIDTH = 26
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [1:0]                mode,
  input  logic                      step_button,
  input  logic                      go,
  input  logic                      halt,
  input  logic [PRESCALE_WIDTH-1:0] divisor,
  input  logic [COUNT_WIDTH-1:0]    step_count,
  input  logic                      breakpoint_enable,
  input  logic [ADDR_WIDTH-1:0]     breakpoint_address,
  input  logic [ADDR_WIDTH-1:0]     pc,
  output logic                      cpu_enable,
  output logic [COUNT_WIDTH-1:0]    cycle_count,
  output logic                      register_reset,
  output logic                      running,
  output logic                      done,
  output logic                      breakpoint_hit
);

  typedef enum logic {
    S_HALT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [1:0] MODE_STEP = 2'b00;
  localparam logic [1:0] MODE_RUNN = 2'b10;

  state_t                    r_state, w_state_nxt;
  logic [2:0]                r_sync;
  logic                      w_step_edge;
  logic [1:0]                r_mode, w_mode_nxt;
  logic [PRESCALE_WIDTH-1:0] r_presc, w_presc_nxt;
  logic [PRESCALE_WIDTH-1:0] w_term;
  logic [COUNT_WIDTH-1:0]    r_remaining, w_remaining_nxt;
  logic                      r_first, w_first_nxt;
  logic                      r_cpu_en, w_cpu_en_nxt;
  logic                      r_done, w_done_nxt;
  logic                      r_bp_hit, w_bp_hit_nxt;
  logic                      r_running;
  logic [COUNT_WIDTH-1:0]    r_cycle_count;
  logic                      w_tick;
  logic                      w_bp_match;

  // Divisor 0 behaves like 1, so the terminal prescaler value is never negative.
  assign w_term      = (divisor == '0) ? '0 : divisor - 1'b1;
  assign w_tick      = (r_presc == w_term);
  // The first step after go is exempt so a resume from a breakpoint does not re-hit.
  assign w_bp_match  = breakpoint_enable && !r_first && (pc == breakpoint_address) &&
                       (r_mode != MODE_STEP);
  // Rising edge of the synchronised button (r_sync[0] is the metastability flop).
  assign w_step_edge = r_sync[1] && !r_sync[2];

  // Two-flop synchroniser plus one history flop for the edge detect.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_sync <= '0;
    else        r_sync <= {r_sync[1:0], step_button};
  end

  // Next-state and next-output decode for HALT/RUN.
  always_comb begin
    w_state_nxt     = r_state;
    w_mode_nxt      = r_mode;
    w_presc_nxt     = r_presc;
    w_remaining_nxt = r_remaining;
    w_first_nxt     = r_first;
    w_bp_hit_nxt    = r_bp_hit;
    w_cpu_en_nxt    = 1'b0;
    w_done_nxt      = 1'b0;
    case (r_state)
      S_HALT: begin
        w_cpu_en_nxt = w_step_edge;
        if (go && !halt && (mode != MODE_STEP)) begin
          if ((mode == MODE_RUNN) && (step_count == '0)) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt     = S_RUN;
            w_mode_nxt      = mode;
            w_presc_nxt     = '0;
            w_remaining_nxt = step_count;
            w_first_nxt     = 1'b1;
            w_bp_hit_nxt    = 1'b0;
          end
        end
      end
      S_RUN: begin
        // A prescaler beyond a freshly lowered terminal wraps without a tick.
        w_presc_nxt = (r_presc >= w_term) ? '0 : r_presc + 1'b1;
        if (halt) begin
          w_state_nxt = S_HALT;
          w_done_nxt  = 1'b1;
        end else if (w_tick) begin
          if (w_bp_match) begin
            w_bp_hit_nxt = 1'b1;
            w_state_nxt  = S_HALT;
            w_done_nxt   = 1'b1;
          end else begin
            w_cpu_en_nxt = 1'b1;
            w_first_nxt  = 1'b0;
            if (r_mode == MODE_RUNN) begin
              w_remaining_nxt = r_remaining - 1'b1;
              if (r_remaining == COUNT_WIDTH'(1)) begin
                w_state_nxt = S_HALT;
                w_done_nxt  = 1'b1;
              end
            end
          end
        end
      end
      default: w_state_nxt = S_HALT;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_HALT;
    else        r_state <= w_state_nxt;
  end

  // Datapath and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_mode        <= MODE_STEP;
      r_presc       <= '0;
      r_remaining   <= '0;
      r_first       <= 1'b0;
      r_cpu_en      <= 1'b0;
      r_done        <= 1'b0;
      r_bp_hit      <= 1'b0;
      r_running     <= 1'b0;
      r_cycle_count <= '0;
    end else begin
      r_mode        <= w_mode_nxt;
      r_presc       <= w_presc_nxt;
      r_remaining   <= w_remaining_nxt;
      r_first       <= w_first_nxt;
      r_cpu_en      <= w_cpu_en_nxt;
      r_done        <= w_done_nxt;
      r_bp_hit      <= w_bp_hit_nxt;
      r_running     <= (w_state_nxt == S_RUN);
      // Count lags cpu_enable by one clock so the CPU sees register_reset with its first enable.
      r_cycle_count <= r_cycle_count + COUNT_WIDTH'(r_cpu_en);
    end
  end

  assign cpu_enable     = r_cpu_en;
  assign cycle_count    = r_cycle_count;
  assign register_reset = (r_cycle_count == '0);
  assign running        = r_running;
  assign done           = r_done;
  assign breakpoint_hit = r_bp_hit;

endmodule
